// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// DECODER_ACTIVE_LOW_EN selects the active-low (NAND-style) dout encoding.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_e;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [MAX_OUT_W-1:0] DOUT_INACTIVE = '1;
`else
  localparam logic [MAX_OUT_W-1:0] DOUT_INACTIVE = '0;
`endif

  // Widest one-hot; callers truncate to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(
    input logic [MAX_SEL_W-1:0] idx
  );
    return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Dwell counter and scan index for auto-scan mode.
// Exposes the next index so the owner can register a matching strobe.
module decoder_scan_timer
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] scan_idx,
  output logic [SEL_W-1:0] scan_idx_nxt
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL - 1);

  logic [DW_W-1:0] dwell;
  logic [DW_W-1:0] dwell_nxt;

  // Next dwell/index: clear wins, then count and wrap.
  always_comb begin
    dwell_nxt    = dwell;
    scan_idx_nxt = scan_idx;
    if (clr) begin
      dwell_nxt    = '0;
      scan_idx_nxt = '0;
    end else if (en) begin
      if (dwell == DW_MAX) begin
        dwell_nxt    = '0;
        scan_idx_nxt = scan_idx + 1'b1;
      end else begin
        dwell_nxt = dwell + 1'b1;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell    <= '0;
      scan_idx <= '0;
    end else begin
      dwell    <= dwell_nxt;
      scan_idx <= scan_idx_nxt;
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with direct and auto-scan modes.
// DECODER_ACTIVE_LOW_EN flips dout to the active-low encoding.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic [SEL_W-1:0] scan_idx
);

  localparam logic [OUT_W-1:0] INACT = OUT_W'(DOUT_INACTIVE);

  dec_state_e       state;
  dec_state_e       state_nxt;
  logic [SEL_W-1:0] scan_idx_nxt;
  logic             scan_clr;
  logic             scan_en;
  logic [OUT_W-1:0] sel_hot;
  logic [OUT_W-1:0] scan_hot;

  // Target state comes straight from en/mode every cycle.
  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      !en:          state_nxt = IDLE;
      en && !mode:  state_nxt = DIRECT;
      en && mode:   state_nxt = SCAN;
    endcase
  end

  assign sel_ready = (state == DIRECT);
  assign scan_en   = (state == SCAN);
  assign scan_clr  = (state != SCAN) || (state_nxt != SCAN);

  assign sel_hot  = OUT_W'(onehot(MAX_SEL_W'(sel)) ^ DOUT_INACTIVE);
  assign scan_hot = OUT_W'(onehot(MAX_SEL_W'(scan_idx_nxt)) ^ DOUT_INACTIVE);

  decoder_scan_timer #(
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr          (scan_clr),
    .en           (scan_en),
    .scan_idx     (scan_idx),
    .scan_idx_nxt (scan_idx_nxt)
  );

  // FSM plus registered dout/dout_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dout       <= INACT;
      dout_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state_nxt)
        DIRECT: begin
          if (state != DIRECT) begin
            dout       <= INACT;
            dout_valid <= 1'b0;
          end else if (sel_valid) begin
            dout       <= sel_hot;
            dout_valid <= 1'b1;
          end
        end
        SCAN: begin
          dout       <= scan_hot;
          dout_valid <= 1'b1;
        end
        default: begin
          dout       <= INACT;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

Parametrised, registered binary-to-one-hot decoder with two modes. In direct mode it decodes a handshaked select word. In scan mode it steps through every output automatically, holding each one for a programmable dwell time. It generalises the team's 2-to-4 combinational decoder to SEL_W inputs and 2^SEL_W outputs. It sits between control logic and downstream enables such as display-digit strobes, chip selects and bank enables.

## Interface
- SEL_W, default 2: select width. Output count OUT_W = 2**SEL_W is derived, not overridable. Legal range 1..6.
- DWELL, default 4: cycles each output stays active in scan mode. Must be ≥1.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  block enable. Low forces IDLE.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- sel  input  SEL_W  select word for direct mode.
- sel_valid  input  1  sel is valid.
- sel_ready  output  1  block accepts sel this cycle.
- dout  output  OUT_W  one-hot decoded output, registered.
- dout_valid  output  1  dout holds a decoded value.
- scan_idx  output  SEL_W  index currently driven in scan mode.

## Operation
- States are IDLE, DIRECT and SCAN. State is evaluated every cycle from en and mode:
  - en=0 → IDLE
  - en=1, mode=0 → DIRECT
  - en=1, mode=1 → SCAN
- IDLE:
  - dout is inactive (all zeros).
  - dout_valid=0, sel_ready=0.
  - scan_idx and the dwell counter are cleared to 0.
- DIRECT:
  - sel_ready=1 combinationally.
  - On sel_valid && sel_ready, at the next edge: dout ← (1 << sel) and dout_valid ← 1.
  - Without a transfer, dout and dout_valid hold.
  - On entering DIRECT from another state, dout is inactive and dout_valid=0 until the first transfer.
- SCAN:
  - sel_ready=0; sel and sel_valid are ignored.
  - dout = 1 << scan_idx, dout_valid=1.
  - The dwell counter counts 0..DWELL-1. At DWELL-1 it wraps to 0 and scan_idx increments.
  - scan_idx wraps from OUT_W-1 to 0.
  - On entering SCAN, scan_idx=0 and dwell=0.
- Mode change mid-operation: takes effect at the next edge. Leaving SCAN clears scan_idx and dwell. Re-entering SCAN always restarts at index 0.
- Exactly one dout bit is active whenever dout_valid=1. No bits are active when dout_valid=0.

## Timing
- Reset values: dout inactive, dout_valid=0, sel_ready=0, scan_idx=0, dwell counter=0, state IDLE.
- rst has priority over en and mode.
- Direct latency: 1 cycle from an accepted sel to dout/dout_valid. Back-to-back transfers are accepted every cycle.
- Scan: the first strobe appears 1 cycle after SCAN is entered. Each index is held exactly DWELL cycles. One full sweep takes OUT_W*DWELL cycles.
- DWELL=1: scan_idx advances every cycle.
- rst asserted mid-scan or mid-transfer: all outputs return to reset values at that edge. Any in-flight sel is dropped.
- sel_ready depends only on state, never on sel_valid (no combinational loop).

## Configuration
- DECODER_ACTIVE_LOW_EN defined:
  - dout is active-low; the active bit is 0 and all others are 1. This is the NAND-style variant.
  - The inactive value and the reset value are all ones.
- DECODER_ACTIVE_LOW_EN not defined: dout is active-high; the inactive value and the reset value are all zeros.
- The macro affects only the dout output stage. Internal state, scan_idx and the handshake are identical in both builds.

## Structure
- Package decoder_pkg holds:
  - the state enum (IDLE, DIRECT, SCAN)
  - the onehot function (index → OUT_W vector)
  - a constant for the dout inactive value, selected by DECODER_ACTIVE_LOW_EN
- Sub-module decoder_scan_timer: the dwell counter plus scan_idx wrap logic, parametrised by SEL_W and DWELL. It takes a clear and an enable input and outputs scan_idx.
- The top-level module holds the FSM, the handshake and the output register.

## Test plan
- Reset, then en=1, mode=0, sel=2'b10, sel_valid=1 for one cycle → next cycle dout=4'b0100 and dout_valid=1; dout holds after sel_valid drops.
- Back-to-back direct transfers sel=0,1,2,3 with SEL_W=2 → dout=0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after acceptance.
- mode=1, DWELL=4, SEL_W=2 → scan_idx sequence 0,1,2,3,0; each dout one-hot held 4 cycles; period 16 cycles; sel_ready=0 throughout.
- Mid-scan at scan_idx=2, switch to mode=0 then back to mode=1 → scan restarts at index 0 with a full 4-cycle dwell; dout_valid=0 in DIRECT until the first transfer.
- rst asserted at scan_idx=3 → next cycle dout inactive, dout_valid=0, scan_idx=0; en=0 gives the same result without rst.
- DECODER_ACTIVE_LOW_EN build, SEL_W=3, sel=5 → dout=8'b11011111; reset value 8'hFF.
